// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch elapsed-time counter: state codes,
// BCD digit limits and the packed HH:MM:SS time type.
// Optional lap capture in stopwatch_counter is enabled with STOPWATCH_LAP_EN.
package stopwatch_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] SEC10_MAX = 4'd5;
    localparam logic [3:0] MIN10_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Most significant digit first so the struct reads like HH:MM:SS in hex.
    typedef struct packed {
        logic [3:0] hour10;
        logic [3:0] hour1;
        logic [3:0] minute10;
        logic [3:0] minute1;
        logic [3:0] second10;
        logic [3:0] second1;
    } bcd_time_t;

    // Digit index 0 is seconds-ones, 5 is hours-tens; only the two tens
    // places below the hour roll over at 5.
    function automatic logic [3:0] digitLimit(input int idx);
        case (idx)
            1:       return SEC10_MAX;
            3:       return MIN10_MAX;
            default: return DIGIT_MAX;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// Single BCD digit incrementer with carry chaining. A digit at (or somehow
// above) its limit wraps to zero and passes the carry on, so no digit can
// ever leave its legal range through an increment.
module bcd_digit_inc (
    input  logic [3:0] digit_i,
    input  logic [3:0] max_i,
    input  logic       carry_in_i,
    output logic [3:0] next_digit_o,
    output logic       carry_out_o
);

    logic atMax;

    assign atMax        = (digit_i >= max_i);
    assign carry_out_o  = carry_in_i & atMax;
    assign next_digit_o = !carry_in_i ? digit_i :
                          (atMax ? 4'd0 : digit_i + 4'd1);

endmodule

// File: rtl/stopwatch_counter.sv
// Elapsed-time up-counter keeping BCD HH:MM:SS, advancing once per
// CLK_PER_SEC clock cycles while running, with target match and overflow.
// Define STOPWATCH_LAP_EN to add the lap input and lap capture registers.
module stopwatch_counter #(
    parameter int CLK_PER_SEC = 50000000,
    parameter int WRAP        = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [3:0] setHour10,
    input  logic [3:0] setHour1,
    input  logic [3:0] setMinute10,
    input  logic [3:0] setMinute1,
    input  logic [3:0] setSecond10,
    input  logic [3:0] setSecond1,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
    output logic [3:0] lapHour10,
    output logic [3:0] lapHour1,
    output logic [3:0] lapMinute10,
    output logic [3:0] lapMinute1,
    output logic [3:0] lapSecond10,
    output logic [3:0] lapSecond1,
`endif
    output logic [3:0] getHour10,
    output logic [3:0] getHour1,
    output logic [3:0] getMinute10,
    output logic [3:0] getMinute1,
    output logic [3:0] getSecond10,
    output logic [3:0] getSecond1,
    output logic       running,
    output logic       reached,
    output logic       overflow
);

    import stopwatch_pkg::*;

    localparam int PS_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_SEC - 1);

    logic [1:0]      state_q, state_d;
    logic [PS_W-1:0] presc_q, presc_d;
    bcd_time_t       count_q, count_d;
    logic            reached_q, reached_d;
    logic            overflow_q, overflow_d;

    bcd_time_t       target;
    logic            targetValid;
    logic [23:0]     incVec;
    logic [6:0]      carryChain;

    assign target = {setHour10, setHour1, setMinute10, setMinute1,
                     setSecond10, setSecond1};
    assign targetValid = (target != '0);

    // Ripple a +1 through the six digits; a carry out of the top digit
    // means the count is sitting at 99:59:59.
    assign carryChain[0] = 1'b1;
    for (genvar i = 0; i < 6; i++) begin : gDigit
        bcd_digit_inc uInc (
            .digit_i      (count_q[4*i +: 4]),
            .max_i        (digitLimit(i)),
            .carry_in_i   (carryChain[i]),
            .next_digit_o (incVec[4*i +: 4]),
            .carry_out_o  (carryChain[i+1])
        );
    end

    // Command decoding (clear > stop > start > tick) and the per-second update.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        count_d    = count_q;
        reached_d  = 1'b0;
        overflow_d = (WRAP != 0) ? 1'b0 : overflow_q;
        if (clear) begin
            state_d    = IDLE;
            presc_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (presc_q == PS_LAST) begin
                        presc_d = '0;
                        if (carryChain[6]) begin
                            overflow_d = 1'b1;
                            if (WRAP != 0) begin
                                count_d = '0;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            count_d = incVec;
                            if (targetValid && (incVec == target)) begin
                                reached_d = 1'b1;
                                state_d   = DONE;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PS_W'(1);
                    end
                end
                PAUSE: begin
                    if (start && !stop) begin
                        state_d = RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, prescaler, count and status flags; reset wins over everything.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            count_q    <= '0;
            reached_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            reached_q  <= reached_d;
            overflow_q <= overflow_d;
        end
    end

    assign getHour10   = count_q.hour10;
    assign getHour1    = count_q.hour1;
    assign getMinute10 = count_q.minute10;
    assign getMinute1  = count_q.minute1;
    assign getSecond10 = count_q.second10;
    assign getSecond1  = count_q.second1;
    assign running     = (state_q == RUN);
    assign reached     = reached_q;
    assign overflow    = overflow_q;

`ifdef STOPWATCH_LAP_EN
    logic      lapPrev_q;
    bcd_time_t lapCount_q;

    // Capture the pre-increment count on a rising lap edge while running.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lapPrev_q  <= 1'b0;
            lapCount_q <= '0;
        end else begin
            lapPrev_q <= lap;
            if (clear) begin
                lapCount_q <= '0;
            end else if ((state_q == RUN) && lap && !lapPrev_q) begin
                lapCount_q <= count_q;
            end
        end
    end

    assign lapHour10   = lapCount_q.hour10;
    assign lapHour1    = lapCount_q.hour1;
    assign lapMinute10 = lapCount_q.minute10;
    assign lapMinute1  = lapCount_q.minute1;
    assign lapSecond10 = lapCount_q.second10;
    assign lapSecond1  = lapCount_q.second1;
`endif

endmodule
